// File: rtl/lcb_word_splitter.sv
// LCB response byte collector: packs byte pairs into 12-bit orbit words and
// steers them to the fast or slow FIFO, with inter-byte timeout and abort.
module lcb_word_splitter #(
  parameter logic [4:0]  BYTES      = 5'd16,
  parameter logic [3:0]  FAST_WORDS = 4'd4,
  parameter logic [15:0] TIMEOUT    = 16'd400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  iData,
  input  logic        strob,
  input  logic        iNewRq,
  input  logic [10:0] sAddr,
  input  logic        fFull,
  input  logic        sFull,
  output logic [11:0] fData,
  output logic        fVal,
  output logic [11:0] sData,
  output logic        sVal,
  output logic [10:0] oSAddr,
  output logic        oDone,
  output logic        oErr,
  output logic [7:0]  oDrop,
  output logic        oBusy
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t      state_q;
  logic [7:0]  b0_q;
  logic [10:0] base_q;
  logic [4:0]  byte_cnt_q;
  logic [3:0]  word_cnt_q;
  logic [15:0] timer_q;
  logic [11:0] fdata_q, sdata_q;
  logic        fval_q, sval_q, done_q, err_q;
  logic [10:0] saddr_q;
  logic [7:0]  drop_q;

  logic        busy, abort_rq, accept, expire, last_byte, emit, to_fast;
  logic [4:0]  byte_cnt_d;
  logic [11:0] word_d;
  logic [10:0] base_d, slow_addr;

  always_comb begin
    busy       = (state_q != IDLE);
    abort_rq   = busy && iNewRq;
    accept     = strob && !abort_rq;
    // A strob in the expiry cycle keeps the packet alive.
    expire     = busy && !strob && (timer_q == TIMEOUT - 16'd1);
    byte_cnt_d = (state_q == IDLE) ? 5'd1 : byte_cnt_q + 5'd1;
    last_byte  = (byte_cnt_d == BYTES);
    // In IDLE/LOW the last byte has no partner: it becomes a lone tail word.
    emit       = accept && ((state_q == HIGH) || last_byte);
    word_d     = (state_q == HIGH) ? {iData[3:0], b0_q} : {4'h0, iData};
    base_d     = (state_q == IDLE) ? sAddr : base_q;
    to_fast    = (word_cnt_q < FAST_WORDS);
    slow_addr  = base_d + {7'd0, word_cnt_q - FAST_WORDS};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      b0_q       <= '0;
      base_q     <= '0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      timer_q    <= '0;
      fdata_q    <= '0;
      sdata_q    <= '0;
      fval_q     <= 1'b0;
      sval_q     <= 1'b0;
      saddr_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      fval_q <= 1'b0;
      sval_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (abort_rq || expire) begin
        err_q      <= 1'b1;
        state_q    <= IDLE;
        byte_cnt_q <= '0;
        word_cnt_q <= '0;
        timer_q    <= '0;
      end else if (accept) begin
        timer_q    <= '0;
        byte_cnt_q <= byte_cnt_d;
        base_q     <= base_d;
        if (emit) begin
          word_cnt_q <= word_cnt_q + 4'd1;
          // Full FIFO drops the word but the word/address sequence still advances.
          if (to_fast) begin
            if (fFull) begin
              if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
            end else begin
              fval_q  <= 1'b1;
              fdata_q <= word_d;
            end
          end else begin
            if (sFull) begin
              if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
            end else begin
              sval_q  <= 1'b1;
              sdata_q <= word_d;
              saddr_q <= slow_addr;
            end
          end
          if (last_byte) begin
            done_q     <= 1'b1;
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
          end else begin
            state_q <= LOW;
          end
        end else begin
          b0_q    <= iData;
          state_q <= HIGH;
        end
      end else if (busy) begin
        timer_q <= timer_q + 16'd1;
      end
    end
  end

  assign fData  = fdata_q;
  assign fVal   = fval_q;
  assign sData  = sdata_q;
  assign sVal   = sval_q;
  assign oSAddr = saddr_q;
  assign oDone  = done_q;
  assign oErr   = err_q;
  assign oDrop  = drop_q;
  assign oBusy  = busy;

endmodule

// File: tb/tb_lcb_word_splitter.sv
// Directed bench for lcb_word_splitter: a 16-byte and a 15-byte instance,
// expected words queued at stimulus time and compared as the DUT emits them.
module tb_lcb_word_splitter;

  logic        clk, rst;
  logic [7:0]  iData;
  logic        strob16, strob15, iNewRq;
  logic [10:0] sAddr;
  logic        fFull, sFull;

  logic [11:0] f16_data, s16_data, f15_data, s15_data;
  logic        f16_val, s16_val, d16, e16, busy16;
  logic        f15_val, s15_val, d15, e15, busy15;
  logic [10:0] s16_addr, s15_addr;
  logic [7:0]  drop16, drop15;

  lcb_word_splitter #(.BYTES(5'd16), .FAST_WORDS(4'd4), .TIMEOUT(16'd400)) u16 (
    .clk(clk), .rst(rst), .iData(iData), .strob(strob16), .iNewRq(iNewRq),
    .sAddr(sAddr), .fFull(fFull), .sFull(sFull),
    .fData(f16_data), .fVal(f16_val), .sData(s16_data), .sVal(s16_val),
    .oSAddr(s16_addr), .oDone(d16), .oErr(e16), .oDrop(drop16), .oBusy(busy16));

  lcb_word_splitter #(.BYTES(5'd15), .FAST_WORDS(4'd4), .TIMEOUT(16'd400)) u15 (
    .clk(clk), .rst(rst), .iData(iData), .strob(strob15), .iNewRq(1'b0),
    .sAddr(sAddr), .fFull(1'b0), .sFull(1'b0),
    .fData(f15_data), .fVal(f15_val), .sData(s15_data), .sVal(s15_val),
    .oSAddr(s15_addr), .oDone(d15), .oErr(e15), .oDrop(drop15), .oBusy(busy15));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_drop = 0;
  int n_f16 = 0, n_s16 = 0, n_d16 = 0, n_e16 = 0;
  int n_f15 = 0, n_s15 = 0, n_d15 = 0;
  logic done_sv16 = 1'b0, done_sv15 = 1'b0;
  logic [11:0] fq16[$], fq15[$];
  logic [22:0] sq16[$], sq15[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitors: pop the scoreboard on every write strobe.
  always @(negedge clk) begin
    logic [11:0] ef;
    logic [22:0] es;
    if (f16_val) begin
      n_f16++;
      if (fq16.size() == 0) chk("f16_unexpected", 1, 0);
      else begin ef = fq16.pop_front(); chk("f16_word", f16_data, ef); end
    end
    if (s16_val) begin
      n_s16++;
      if (sq16.size() == 0) chk("s16_unexpected", 1, 0);
      else begin es = sq16.pop_front(); chk("s16_addr_word", {s16_addr, s16_data}, es); end
    end
    if (d16) begin n_d16++; done_sv16 = s16_val; chk("d16_busy", busy16, 0); end
    if (e16) begin n_e16++; chk("e16_busy", busy16, 0); end
    if (f15_val) begin
      n_f15++;
      if (fq15.size() == 0) chk("f15_unexpected", 1, 0);
      else begin ef = fq15.pop_front(); chk("f15_word", f15_data, ef); end
    end
    if (s15_val) begin
      n_s15++;
      if (sq15.size() == 0) chk("s15_unexpected", 1, 0);
      else begin es = sq15.pop_front(); chk("s15_addr_word", {s15_addr, s15_data}, es); end
    end
    if (d15) begin n_d15++; done_sv15 = s15_val; end
  end

  // Push the first nwords words of a packet of bytes st, st+1, ...
  task automatic expect_pkt(input bit is15, input logic [10:0] sa, input logic [7:0] st,
                            input int nb, input int nwords);
    logic [7:0]  lo, hi;
    logic [11:0] w12;
    for (int w = 0; w < nwords; w++) begin
      lo  = st + 8'(2*w);
      hi  = (2*w+1 < nb) ? st + 8'(2*w+1) : 8'h00;
      w12 = {hi[3:0], lo};
      if (w < 4) begin
        if (!is15 && fFull) exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
        else if (is15) fq15.push_back(w12);
        else fq16.push_back(w12);
      end else begin
        if (!is15 && sFull) exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
        else if (is15) sq15.push_back({sa + 11'(w-4), w12});
        else sq16.push_back({sa + 11'(w-4), w12});
      end
    end
  endtask

  task automatic send(input bit is15, input logic [7:0] st, input int nb, input int gap,
                      input int long_idx, input int long_gap);
    for (int i = 0; i < nb; i++) begin
      iData = st + 8'(i);
      if (is15) strob15 = 1'b1; else strob16 = 1'b1;
      @(negedge clk);
      strob15 = 1'b0;
      strob16 = 1'b0;
      repeat (((i == long_idx) ? long_gap : gap) - 1) @(negedge clk);
    end
  endtask

  task automatic chk_zero16(input string tag);
    chk({tag, "_fval"}, f16_val, 0);
    chk({tag, "_sval"}, s16_val, 0);
    chk({tag, "_fdata"}, f16_data, 0);
    chk({tag, "_sdata"}, s16_data, 0);
    chk({tag, "_saddr"}, s16_addr, 0);
    chk({tag, "_done"}, d16, 0);
    chk({tag, "_err"}, e16, 0);
    chk({tag, "_drop"}, drop16, 0);
    chk({tag, "_busy"}, busy16, 0);
  endtask

  initial begin
    int f0, s0, d0, e0;
    rst = 1'b1; iData = 8'h00; strob16 = 1'b0; strob15 = 1'b0; iNewRq = 1'b0;
    sAddr = 11'd0; fFull = 1'b0; sFull = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero16("reset");
    chk("reset_u15_busy", busy15, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: full 16-byte packet at 200-clk spacing
    sAddr = 11'd100;
    expect_pkt(0, 11'd100, 8'h01, 16, 8);
    send(0, 8'h01, 16, 200, -1, 0);
    repeat (3) @(negedge clk);
    chk("t1_fast_cnt", n_f16, 4);
    chk("t1_slow_cnt", n_s16, 4);
    chk("t1_done_cnt", n_d16, 1);
    chk("t1_err_cnt", n_e16, 0);
    chk("t1_done_with_sval", done_sv16, 1);
    chk("t1_fdata_hold", f16_data, 12'h807);
    chk("t1_sdata_hold", {s16_addr, s16_data}, {11'd103, 12'h00F});

    // 2: odd length, lone tail byte forms the last word
    expect_pkt(1, 11'd100, 8'h01, 15, 8);
    send(1, 8'h01, 15, 10, -1, 0);
    repeat (3) @(negedge clk);
    chk("t2_fast_cnt", n_f15, 4);
    chk("t2_slow_cnt", n_s15, 4);
    chk("t2_done_cnt", n_d15, 1);
    chk("t2_done_with_sval", done_sv15, 1);

    // 3: timeout after 5 bytes
    f0 = n_f16; s0 = n_s16; d0 = n_d16; e0 = n_e16;
    expect_pkt(0, 11'd100, 8'h01, 5, 2);
    send(0, 8'h01, 5, 10, -1, 0);
    for (int i = 0; i < 600 && n_e16 == e0; i++) @(negedge clk);
    chk("t3_err", n_e16 - e0, 1);
    chk("t3_fast_cnt", n_f16 - f0, 2);
    chk("t3_slow_cnt", n_s16 - s0, 0);
    chk("t3_busy", busy16, 0);
    expect_pkt(0, 11'd100, 8'h21, 16, 8);
    send(0, 8'h21, 16, 5, -1, 0);
    repeat (3) @(negedge clk);
    chk("t3_clean_done", n_d16 - d0, 1);
    chk("t3_clean_noerr", n_e16 - e0, 1);
    // strob exactly at expiry keeps the packet
    expect_pkt(0, 11'd100, 8'h31, 16, 8);
    send(0, 8'h31, 16, 5, 4, 400);
    repeat (3) @(negedge clk);
    chk("t3_edge_done", n_d16 - d0, 2);
    chk("t3_edge_noerr", n_e16 - e0, 1);

    // 4: new request in idle does nothing, mid-packet aborts (coincident strob dropped)
    e0 = n_e16; f0 = n_f16; s0 = n_s16; d0 = n_d16;
    iNewRq = 1'b1; @(negedge clk); iNewRq = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_idle_rq", n_e16 - e0, 0);
    expect_pkt(0, 11'd100, 8'h51, 9, 4);
    send(0, 8'h51, 9, 10, -1, 0);
    iData = 8'hAA; strob16 = 1'b1; iNewRq = 1'b1;
    @(negedge clk);
    strob16 = 1'b0; iNewRq = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_err", n_e16 - e0, 1);
    chk("t4_fast_cnt", n_f16 - f0, 4);
    chk("t4_slow_cnt", n_s16 - s0, 0);
    chk("t4_busy", busy16, 0);
    sAddr = 11'd500;
    expect_pkt(0, 11'd500, 8'h61, 16, 8);
    send(0, 8'h61, 16, 4, -1, 0);
    repeat (3) @(negedge clk);
    chk("t4_next_done", n_d16 - d0, 1);
    chk("t4_next_slow", n_s16 - s0, 4);

    // 5: slow FIFO full drops slow words, drop counter saturates
    sFull = 1'b1; sAddr = 11'd100; d0 = n_d16; s0 = n_s16;
    expect_pkt(0, 11'd100, 8'h01, 16, 8);
    send(0, 8'h01, 16, 2, -1, 0);
    repeat (3) @(negedge clk);
    chk("t5_drop4", drop16, exp_drop);
    chk("t5_done", n_d16 - d0, 1);
    chk("t5_no_sval", n_s16 - s0, 0);
    for (int p = 0; p < 69; p++) begin
      expect_pkt(0, 11'd100, 8'(p), 16, 8);
      send(0, 8'(p), 16, 2, -1, 0);
    end
    repeat (3) @(negedge clk);
    chk("t5_drop_sat", drop16, 255);
    chk("t5_drop_model", drop16, exp_drop);
    chk("t5_done70", n_d16 - d0, 70);
    sFull = 1'b0;

    // 6: asynchronous reset mid-packet
    exp_drop = 0;
    expect_pkt(0, 11'd100, 8'h71, 5, 2);
    send(0, 8'h71, 5, 10, -1, 0);
    #3 rst = 1'b1;
    #1 chk_zero16("async_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    d0 = n_d16; e0 = n_e16;
    expect_pkt(0, 11'd100, 8'h81, 16, 8);
    send(0, 8'h81, 16, 3, -1, 0);
    repeat (3) @(negedge clk);
    chk("t6_done", n_d16 - d0, 1);
    chk("t6_noerr", n_e16 - e0, 0);
    chk("t6_drop", drop16, 0);

    chk("end_q16", fq16.size() + sq16.size(), 0);
    chk("end_q15", fq15.size() + sq15.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
